// File: rtl/oam_dma_controller_if.sv
// Bus bundle between the CPU core, the sprite-DMA sequencer and the system bus.
// The slave modport is the DMA block; the master modport is the CPU/memory side.
interface oam_dma_controller_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_r_nw;
    logic [7:0]  bus_data_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_r_nw;
    logic        cpu_halt;
    logic        dma_busy;

    modport master (
        output cpu_addr,
        output cpu_data_out,
        output cpu_r_nw,
        output bus_data_in,
        input  bus_addr,
        input  bus_data_out,
        input  bus_r_nw,
        input  cpu_halt,
        input  dma_busy
    );

    modport slave (
        input  cpu_addr,
        input  cpu_data_out,
        input  cpu_r_nw,
        input  bus_data_in,
        output bus_addr,
        output bus_data_out,
        output bus_r_nw,
        output cpu_halt,
        output dma_busy
    );
endinterface

// File: rtl/oam_dma_controller.sv
// Sprite-DMA sequencer: a CPU write to DMA_REG halts the CPU and copies one 256-byte page
// to the OAM data port as read/write pairs; otherwise the CPU bus passes straight through.
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_PORT = 16'h2004
) (
    input logic                  clk_ph1,
    input logic                  rst,
    oam_dma_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StRead,
        StWrite
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_buf_q, data_buf_d;
    logic       odd_q;

    // State register
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; odd free-runs so the first read lands on a fixed bus phase
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            data_buf_q <= 8'h00;
            odd_q      <= 1'b0;
        end else begin
            page_q     <= page_d;
            idx_q      <= idx_d;
            data_buf_q <= data_buf_d;
            odd_q      <= ~odd_q;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_buf_d = data_buf_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.cpu_r_nw && (bus.cpu_addr == DMA_REG)) begin
                    page_d  = bus.cpu_data_out;
                    idx_d   = 8'h00;
                    state_d = StHalt;
                end
            end
            StHalt:  state_d = odd_q ? StAlign : StRead;
            StAlign: state_d = StRead;
            StRead: begin
                data_buf_d = bus.bus_data_in;
                state_d    = StWrite;
            end
            StWrite: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hFF) ? StIdle : StRead;
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus drive: passthrough in idle, forced read during the dummy cycles
    always_comb begin
        bus.bus_addr     = bus.cpu_addr;
        bus.bus_data_out = bus.cpu_data_out;
        bus.bus_r_nw     = bus.cpu_r_nw;
        unique case (state_q)
            StIdle: ;
            StHalt, StAlign: begin
                bus.bus_data_out = data_buf_q;
                bus.bus_r_nw     = 1'b1;
            end
            StRead: begin
                bus.bus_addr     = {page_q, idx_q};
                bus.bus_data_out = data_buf_q;
                bus.bus_r_nw     = 1'b1;
            end
            StWrite: begin
                bus.bus_addr     = OAM_PORT;
                bus.bus_data_out = data_buf_q;
                bus.bus_r_nw     = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.cpu_halt = (state_q != StIdle);
    assign bus.dma_busy = (state_q != StIdle);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Randomized scoreboard bench: each trigger pushes the full expected halted bus-cycle
// sequence; a negedge monitor pops and compares it, and checks passthrough while idle.
module tb_oam_dma_controller;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_PORT = 16'h2004;

    typedef struct packed {
        logic [1:0]  kind;   // 0 dummy, 1 read, 2 write
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk_ph1 = 1'b0;
    logic rst     = 1'b0;
    logic mon_en  = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   passes  = 0;
    int   dma_writes = 0;
    logic [7:0] mem [0:65535];
    exp_t exp_q[$];

    oam_dma_controller_if dif ();

    oam_dma_controller #(
        .DMA_REG  (DMA_REG),
        .OAM_PORT (OAM_PORT)
    ) dut (
        .clk_ph1 (clk_ph1),
        .rst     (rst),
        .bus     (dif)
    );

    always #5 clk_ph1 = ~clk_ph1;

    assign dif.bus_data_in = mem[dif.bus_addr];

    // Parity model: odd is 0 in the first cycle after a reset edge and flips every cycle
    always @(posedge clk_ph1) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cpu_drive(input logic [15:0] a, input logic [7:0] d, input logic rnw);
        dif.cpu_addr     = a;
        dif.cpu_data_out = d;
        dif.cpu_r_nw     = rnw;
    endtask

    always @(negedge clk_ph1) begin
        exp_t e;
        if (mon_en) begin
            if (!rst) begin
                exp_q.delete();
            end else if (dif.cpu_halt) begin
                chk("busy_mirror_hi", dif.dma_busy, 1);
                chk("halt_cycle_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.kind == 2'd0) begin
                        chk("dummy_addr", dif.bus_addr, dif.cpu_addr);
                        chk("dummy_rnw", dif.bus_r_nw, 1);
                    end else if (e.kind == 2'd1) begin
                        chk("read_addr", dif.bus_addr, e.addr);
                        chk("read_rnw", dif.bus_r_nw, 1);
                    end else begin
                        chk("write_addr", dif.bus_addr, e.addr);
                        chk("write_rnw", dif.bus_r_nw, 0);
                        chk("write_data", dif.bus_data_out, e.data);
                        dma_writes++;
                    end
                end
            end else begin
                chk("busy_mirror_lo", dif.dma_busy, 0);
                chk("queue_drained", exp_q.size(), 0);
                exp_q.delete();
                chk("pass_addr", dif.bus_addr, dif.cpu_addr);
                chk("pass_data", dif.bus_data_out, dif.cpu_data_out);
                chk("pass_rnw", dif.bus_r_nw, dif.cpu_r_nw);
            end
        end
    end

    // One transfer; retrig_at is a relative cycle (0 = HALT), reset_wr a WRITE index (-1 none)
    task automatic run_transfer(input logic [7:0] page, input bit want_odd,
                                input int retrig_at, input int reset_wr);
        int   a;
        int   halted;
        int   reset_at;
        exp_t e;
        logic [15:0] busy_addr;
        @(posedge clk_ph1); #1;
        cpu_drive(16'h8000, 8'h00, 1'b1);
        if (cyc[0] == want_odd) begin
            @(posedge clk_ph1); #1;
        end
        cpu_drive(DMA_REG, page, 1'b0);
        @(posedge clk_ph1); #1;
        a = cyc[0] ? 1 : 0;
        e.kind = 2'd0; e.addr = 16'h0; e.data = 8'h0;
        exp_q.push_back(e);
        if (a == 1) exp_q.push_back(e);
        for (int i = 0; i < 256; i++) begin
            e.kind = 2'd1; e.addr = {page, i[7:0]}; e.data = 8'h0;
            exp_q.push_back(e);
            e.kind = 2'd2; e.addr = OAM_PORT; e.data = mem[{page, i[7:0]}];
            exp_q.push_back(e);
        end
        busy_addr = 16'($urandom_range(0, 16'h3FFF));
        cpu_drive(busy_addr, 8'($urandom), 1'b1);
        reset_at   = (reset_wr >= 0) ? 2 + a + 2 * reset_wr : -1;
        dma_writes = 0;
        halted     = 0;
        for (int r = 0; r < 700; r++) begin
            if (r == retrig_at)     cpu_drive(DMA_REG, 8'h03, 1'b0);
            if (r == retrig_at + 1) cpu_drive(busy_addr, 8'($urandom), 1'b1);
            if (r == reset_at)      rst = 1'b0;
            @(negedge clk_ph1);
            if (!dif.cpu_halt) break;
            halted++;
            @(posedge clk_ph1); #1;
            rst = 1'b1;
            if (r == reset_at) break;
        end
        if (reset_wr >= 0) begin
            @(negedge clk_ph1);
            chk("reset_halt", dif.cpu_halt, 0);
            chk("reset_busy", dif.dma_busy, 0);
            chk("reset_pass_addr", dif.bus_addr, dif.cpu_addr);
            chk("reset_writes", dma_writes, reset_wr);
        end else begin
            chk("halt_length", halted, 513 + a);
            chk("oam_writes", dma_writes, 256);
        end
        @(posedge clk_ph1); #1;
        cpu_drive(16'h8000, 8'h00, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        cpu_drive(16'h8000, 8'h00, 1'b1);
        rst = 1'b0;
        repeat (3) @(posedge clk_ph1);
        @(negedge clk_ph1);
        chk("rst_halt", dif.cpu_halt, 0);
        chk("rst_busy", dif.dma_busy, 0);
        chk("rst_rnw", dif.bus_r_nw, dif.cpu_r_nw);
        @(posedge clk_ph1); #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Passthrough write then read
        cpu_drive(16'h0010, 8'h77, 1'b0);
        @(negedge clk_ph1);
        chk("pt_wr_addr", dif.bus_addr, 16'h0010);
        chk("pt_wr_data", dif.bus_data_out, 8'h77);
        chk("pt_wr_rnw", dif.bus_r_nw, 0);
        @(posedge clk_ph1); #1;
        cpu_drive(16'h0011, 8'h00, 1'b1);
        @(negedge clk_ph1);
        chk("pt_rd_addr", dif.bus_addr, 16'h0011);
        chk("pt_rd_rnw", dif.bus_r_nw, 1);
        chk("pt_halt", dif.cpu_halt, 0);

        run_transfer(8'h02, 1'b0, -1, -1);
        run_transfer(8'h02, 1'b1, -1, -1);
        run_transfer(8'h02, 1'($urandom_range(0, 1)), 60, -1);
        run_transfer(8'h05, 1'($urandom_range(0, 1)), -1, 100);
        run_transfer(8'hFF, 1'b0, -1, -1);
        run_transfer(8'h20, 1'b1, -1, -1);
        run_transfer(8'h40, 1'($urandom_range(0, 1)), -1, -1);
        for (int t = 0; t < 3; t++) begin
            run_transfer(8'($urandom), 1'($urandom_range(0, 1)), -1, -1);
        end

        repeat (3) @(posedge clk_ph1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sprite-DMA sequencer and bus arbiter placed between the CPU core and the system bus. A CPU write to $4014 halts the CPU and transfers one 256-byte page, $XX00-$XXFF, to the PPU OAM data port $2004 as 256 read/write pairs. While idle, the block passes CPU bus signals straight through. While active, it owns the address bus, the data-out bus and R/nW.

## Interface
Parameters:
- DMA_REG, 16'h4014, CPU address that triggers a transfer
- OAM_PORT, 16'h2004, destination address of every DMA write

Ports:
- clk_ph1  in  1  system clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- cpu_addr  in  16  CPU address bus
- cpu_data_out  in  8  CPU write data
- cpu_r_nw  in  1  CPU read/not-write
- bus_data_in  in  8  read data returned from the system bus
- bus_addr  out  16  arbitrated address bus
- bus_data_out  out  8  arbitrated write data
- bus_r_nw  out  1  arbitrated read/not-write
- cpu_halt  out  1  holds the CPU (freezes IR, PC and cycle counter) while high
- dma_busy  out  1  high in every state except IDLE (mirrors cpu_halt)

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE. Registers:
  - page[7:0]
  - idx[7:0]
  - buf[7:0]
  - odd: parity flag that toggles on every clk_ph1 edge and resets to 0
- IDLE:
  - bus_addr=cpu_addr, bus_data_out=cpu_data_out, bus_r_nw=cpu_r_nw (combinational passthrough).
  - When cpu_r_nw==0 and cpu_addr==DMA_REG at a clk_ph1 edge: page<=cpu_data_out, idx<=0, go to HALT.
- HALT:
  - One dummy cycle. bus_addr=cpu_addr, bus_r_nw=1 (forced read, no write escapes).
  - Next state is ALIGN if odd==1 at the edge, otherwise READ.
- ALIGN: one dummy cycle, same bus drive as HALT. Next state is READ.
- READ:
  - bus_addr={page,idx}, bus_r_nw=1, bus_data_out=buf.
  - buf<=bus_data_in at the edge leaving READ. Next state is WRITE.
- WRITE:
  - bus_addr=OAM_PORT, bus_r_nw=0, bus_data_out=buf.
  - idx<=idx+1 (8-bit, wraps).
  - If idx==8'hFF, go to IDLE. Otherwise go to READ.
- cpu_halt and dma_busy = (state != IDLE). Both are registered state decodes with no combinational path from cpu_* inputs.
- While not IDLE, cpu_* inputs are ignored. A further write to DMA_REG during a transfer does not restart it or change page.
- Every page value is legal, including $20-$3F (the source reads hit PPU registers as ordinary reads) and $40 (the source range includes DMA_REG itself; the read there is ordinary).
- Reset while rst==0 at an edge:
  - state<=IDLE, idx<=0, page<=0, buf<=0, odd<=0.
  - Outputs return to passthrough on the next cycle. Reset in mid-transfer abandons it; OAM keeps whatever was already written.

## Timing
- Trigger cycle N (the CPU write to $4014) completes normally on the bus.
- cpu_halt rises for cycle N+1.
- Halted length is 513 cycles with odd==0 at the HALT edge, 514 with odd==1:
  - 1 HALT
  - optionally 1 ALIGN
  - 256 × (READ, WRITE)
- READ k is at relative cycle 1+a+2k and WRITE k at 2+a+2k (a = 0 or 1 for ALIGN).
- Read-to-write latency is one cycle: data captured at the end of READ k is driven during WRITE k.
- cpu_halt falls at the edge ending WRITE 255. The CPU resumes with the passthrough bus in the following cycle.
- Reset values: bus_r_nw follows cpu_r_nw (passthrough), cpu_halt=0, dma_busy=0.

## Test plan
- Even start:
  - Stimulus: reset, align so odd==0 at the HALT edge, CPU writes $02 to $4014, memory $0200+i=i^8'h5A.
  - Required response: cpu_halt high for exactly 513 cycles; 256 writes to $2004 carrying $5A, $5B, …, in order; reads hit $0200-$02FF ascending.
- Odd start: same stimulus with odd==1 at the HALT edge -> 514 halted cycles; the first READ is preceded by two dummy cycles, neither of which writes.
- Retrigger ignored: a write of $03 to $4014 on cpu_* during busy -> no effect; all reads stay in page $02; total length unchanged.
- Reset mid-transfer: rst=0 for one edge during WRITE 100 -> next cycle has cpu_halt=0, dma_busy=0 and a passthrough bus; exactly 100 OAM writes were completed.
- Passthrough: in IDLE, CPU writes $77 to $0010 and reads $0011 -> bus mirrors cpu_addr, cpu_data_out and cpu_r_nw in the same cycle; cpu_halt stays 0.
- Wrap: page $FF -> reads $FF00-$FFFF; idx wraps to 0 and the block returns to IDLE after WRITE 255 with no 257th access.
